hatch_ctrl: RTL

- Central sequencer for the egg-hatching board design.
- Turns the power switch, the debounced start pulse and the heat switch into one hatch state machine.
- Owns the 1 s timebase, the picture-stage counter, the elapsed-seconds counter and the cold-exposure counter.
- Drives the enables and values consumed by the dot-matrix picture logic, the 7-segment display logic and the status LEDs.

---
 rtl/hatch_pkg.sv | 26 ++
 rtl/sec_tick_gen.sv | 47 ++++
 rtl/hatch_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hatch_pkg.sv
// Shared state codes, default timing constants and counter widths for the hatch sequencer.
package hatch_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StIdle     = 3'd1,
    StIncubate = 3'd2,
    StGrow     = 3'd3,
    StDone     = 3'd4,
    StFail     = 3'd5
  } state_e;

  localparam int unsigned TickDivDef   = 1000;
  localparam int unsigned StageSecsDef = 2;
  localparam int unsigned GrowStageDef = 10;
  localparam int unsigned DoneStageDef = 16;
  localparam int unsigned ColdLimitDef = 5;

  localparam int unsigned StageW   = 5;
  localparam int unsigned ElapsedW = 7;
  localparam int unsigned ColdW    = 3;
  localparam int unsigned PhaseW   = 4;

  localparam logic [ElapsedW-1:0] ElapsedMax = 7'd99;

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler producing a wrap strobe for same-edge counter updates and a registered tick pulse.
module sec_tick_gen #(
  parameter int unsigned Div = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic run_i,
  output logic wrap_o,
  output logic tick_o
);

  localparam int unsigned W = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [W-1:0] Last = W'(Div - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  assign wrap_o = run_i && !clr_i && (cnt_q == Last);
  assign tick_o = tick_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == Last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/hatch_ctrl.sv
// Hatch sequencer: power/start/heat inputs drive the state machine, stage, elapsed and cold counters.
module hatch_ctrl
  import hatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TickDivDef,
  parameter int unsigned STAGE_SECS = StageSecsDef,
  parameter int unsigned GROW_STAGE = GrowStageDef,
  parameter int unsigned DONE_STAGE = DoneStageDef,
  parameter int unsigned COLD_LIMIT = ColdLimitDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                power,
  input  logic                start_pulse,
  input  logic                heat,
  output logic [2:0]          state,
  output logic [StageW-1:0]   stage,
  output logic [ElapsedW-1:0] elapsed,
  output logic [ColdW-1:0]    cold_sec,
  output logic                sec_tick,
  output logic                mat_en,
  output logic                seg_en,
  output logic                led_ok,
  output logic                led_fail
);

  localparam logic [StageW-1:0] GrowL      = StageW'(GROW_STAGE);
  localparam logic [StageW-1:0] DoneL      = StageW'(DONE_STAGE);
  localparam logic [ColdW-1:0]  ColdL      = ColdW'(COLD_LIMIT);
  localparam logic [PhaseW-1:0] PhaseLast  = PhaseW'(STAGE_SECS - 1);

  state_e              st_q, st_d;
  logic [StageW-1:0]   stage_q, stage_d;
  logic [ElapsedW-1:0] elapsed_q, elapsed_d;
  logic [ColdW-1:0]    cold_q, cold_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic                mat_en_q, seg_en_q, led_ok_q, led_fail_q;
  logic                clr, run, wrap, tick;

  assign run = (st_q == StIncubate) || (st_q == StGrow);

  sec_tick_gen #(
    .Div(TICK_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (clr),
    .run_i (run),
    .wrap_o(wrap),
    .tick_o(tick)
  );

  always_comb begin
    st_d      = st_q;
    stage_d   = stage_q;
    elapsed_d = elapsed_q;
    cold_d    = cold_q;
    phase_d   = phase_q;
    clr       = 1'b0;
    case (st_q)
      StOff: st_d = StIdle;
      StIdle: begin
        if (start_pulse) begin
          st_d      = StIncubate;
          clr       = 1'b1;
          stage_d   = '0;
          elapsed_d = '0;
          cold_d    = '0;
          phase_d   = '0;
        end
      end
      StIncubate: begin
        if (heat) cold_d = '0;
        if (wrap) begin
          if (elapsed_q != ElapsedMax) elapsed_d = elapsed_q + 1'b1;
          if (heat) begin
            if (phase_q == PhaseLast) begin
              phase_d = '0;
              stage_d = stage_q + 1'b1;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end else begin
            cold_d = cold_q + 1'b1;
          end
          // Opposite heat values make these two exits mutually exclusive.
          if (stage_d == GrowL) st_d = StGrow;
          else if (cold_d == ColdL) st_d = StFail;
        end
      end
      StGrow: begin
        cold_d = '0;
        if (wrap) begin
          if (elapsed_q != ElapsedMax) elapsed_d = elapsed_q + 1'b1;
          if (phase_q == PhaseLast) begin
            phase_d = '0;
            stage_d = stage_q + 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
          if (stage_d == DoneL) st_d = StDone;
        end
      end
      StDone, StFail: begin
        if (start_pulse) begin
          st_d      = StIdle;
          stage_d   = '0;
          elapsed_d = '0;
        end
      end
      default: st_d = StOff;
    endcase

    if (!power) begin
      st_d      = StOff;
      stage_d   = '0;
      elapsed_d = '0;
      cold_d    = '0;
      phase_d   = '0;
      clr       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= StOff;
      stage_q    <= '0;
      elapsed_q  <= '0;
      cold_q     <= '0;
      phase_q    <= '0;
      mat_en_q   <= 1'b0;
      seg_en_q   <= 1'b0;
      led_ok_q   <= 1'b0;
      led_fail_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      stage_q    <= stage_d;
      elapsed_q  <= elapsed_d;
      cold_q     <= cold_d;
      phase_q    <= phase_d;
      mat_en_q   <= (st_d != StOff);
      seg_en_q   <= (st_d != StOff) && (st_d != StIdle);
      led_ok_q   <= (st_d == StDone);
      led_fail_q <= (st_d == StFail);
    end
  end

  assign state    = st_q;
  assign stage    = stage_q;
  assign elapsed  = elapsed_q;
  assign cold_sec = cold_q;
  assign sec_tick = tick;
  assign mat_en   = mat_en_q;
  assign seg_en   = seg_en_q;
  assign led_ok   = led_ok_q;
  assign led_fail = led_fail_q;

endmodule
